// File: rtl/uart_pkg.sv
// Shared definitions for the UART image loader: FSM state encoding and default sizing.
package uart_pkg;

   localparam int DEF_CLKS_PER_BIT = 434;
   localparam int DEF_IMG_BYTES    = 65536;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE       = 3'd0;
   localparam state_t S_WAIT_START = 3'd1;
   localparam state_t S_START      = 3'd2;
   localparam state_t S_DATA       = 3'd3;
   localparam state_t S_STOP       = 3'd4;
   localparam state_t S_WRITE      = 3'd5;
   localparam state_t S_DONE       = 3'd6;

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level UART receiver: rx synchronizer, bit timer and START/DATA/STOP sequencing.
// byte_valid_o / stop_err_o are single-cycle strobes coincident with the stop-bit sample.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       stop_err_o
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

   logic          rx_s1_q, rx_s2_q;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_o = 1'b0;
      stop_err_o   = 1'b0;
      if (!en_i) begin
         state_d   = S_IDLE;
         timer_d   = '0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE, S_WAIT_START: begin
               state_d = S_WAIT_START;
               if (!rx_s2_q) begin
                  state_d = S_START;
                  timer_d = '0;
               end
            end
            S_START: begin
               // Mid-start-bit recheck rejects glitches shorter than half a bit.
               if (timer_q == T_HALF) begin
                  timer_d   = '0;
                  bit_cnt_d = '0;
                  state_d   = rx_s2_q ? S_WAIT_START : S_DATA;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            S_DATA: begin
               if (timer_q == T_FULL) begin
                  timer_d = '0;
                  shift_d = {rx_s2_q, shift_q[7:1]};
                  if (bit_cnt_q == 3'd7) state_d = S_STOP;
                  else bit_cnt_d = bit_cnt_q + 3'd1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            S_STOP: begin
               if (timer_q == T_FULL) begin
                  timer_d      = '0;
                  state_d      = S_WAIT_START;
                  byte_valid_o = rx_s2_q;
                  stop_err_o   = !rx_s2_q;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   assign byte_o = shift_q;

endmodule

// File: rtl/uart_rx_loader.sv
// Loads IMG_BYTES bytes received over UART into data memory at consecutive addresses.
// The receive core runs only while this FSM sits in WAIT_START; it owns START/DATA/STOP.
module uart_rx_loader
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int IMG_BYTES    = DEF_IMG_BYTES,
   parameter int ADDR_W       = 20
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start_load,
   input  logic              rx,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [7:0]        dm_data,
   output logic              dm_wr,
   output logic              busy,
   output logic              load_done,
   output logic              frame_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
   logic [7:0]        dm_data_q, dm_data_d;
   logic              ferr_q, ferr_d;

   logic [7:0] rx_byte;
   logic       rx_valid, rx_stop_err;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clock       (clock),
      .rst_n       (rst_n),
      .en_i        (state_q == S_WAIT_START),
      .rx_i        (rx),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid),
      .stop_err_o  (rx_stop_err)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         dm_addr_q <= '0;
         dm_data_q <= '0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         dm_addr_q <= dm_addr_d;
         dm_data_q <= dm_data_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      dm_addr_d = dm_addr_q;
      dm_data_d = dm_data_q;
      ferr_d    = ferr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_load) begin
               state_d = S_WAIT_START;
               addr_d  = '0;
               ferr_d  = 1'b0;
            end
         end
         S_WAIT_START: begin
            // Write port is registered here so addr/data are stable for the whole WRITE cycle.
            if (rx_valid) begin
               state_d   = S_WRITE;
               dm_addr_d = addr_q;
               dm_data_d = rx_byte;
            end
            if (rx_stop_err) ferr_d = 1'b1;
         end
         S_WRITE: begin
            // Stop at the last address rather than incrementing, so a full 2^ADDR_W image never wraps.
            if (addr_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_WAIT_START;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dm_addr   = dm_addr_q;
   assign dm_data   = dm_data_q;
   assign dm_wr     = (state_q == S_WRITE);
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign load_done = (state_q == S_DONE);
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader with CLKS_PER_BIT=4, IMG_BYTES=3.
module tb_uart_rx_loader;

   localparam int CPB = 4;
   localparam int AW  = 20;

   logic          clock, rst_n, start_load, rx;
   logic [AW-1:0] dm_addr;
   logic [7:0]    dm_data;
   logic          dm_wr, busy, load_done, frame_err;

   uart_rx_loader #(.CLKS_PER_BIT(CPB), .IMG_BYTES(3), .ADDR_W(AW)) dut (
      .clock(clock), .rst_n(rst_n), .start_load(start_load), .rx(rx),
      .dm_addr(dm_addr), .dm_data(dm_data), .dm_wr(dm_wr),
      .busy(busy), .load_done(load_done), .frame_err(frame_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          busy_cnt = 0;

   always @(negedge clock) begin
      if (dm_wr) begin
         wa.push_back(32'(dm_addr));
         wd.push_back(32'(dm_data));
      end
      if (busy) busy_cnt = busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wr_a(input int i);
      return (i < wa.size()) ? wa[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] wr_d(input int i);
      return (i < wd.size()) ? wd[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < n; i++) begin
         rx = b[i];
         tick(CPB);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bits(b, 8);
      rx = stop;
      tick(CPB);
      rx = 1'b1;
      tick(2 * CPB);
   endtask

   task automatic pulse_start();
      start_load = 1'b1;
      tick(1);
      start_load = 1'b0;
   endtask

   int base;
   int bsave;

   initial begin
      rst_n = 1'b0; rx = 1'b1; start_load = 1'b0;
      tick(3);
      chk("rst_dm_wr", 32'(dm_wr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_load_done", 32'(load_done), 0);
      chk("rst_dm_addr", 32'(dm_addr), 0);
      rst_n = 1'b1;
      tick(4);

      // Bytes while idle are ignored
      bsave = busy_cnt;
      send_byte(8'hA5, 1'b1);
      chk("idle_no_write", 32'(wa.size()), 0);
      chk("idle_busy_never", 32'(busy_cnt - bsave), 0);

      // Full three-byte load
      pulse_start();
      chk("armed_busy", 32'(busy), 1);
      base = wa.size();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'hFF, 1'b1);
      chk("load_nwr", 32'(wa.size() - base), 3);
      chk("load_a0", wr_a(base), 32'h0);
      chk("load_d0", wr_d(base), 32'hA5);
      chk("load_a1", wr_a(base + 1), 32'h1);
      chk("load_d1", wr_d(base + 1), 32'h3C);
      chk("load_a2", wr_a(base + 2), 32'h2);
      chk("load_d2", wr_d(base + 2), 32'hFF);
      chk("load_done", 32'(load_done), 1);
      chk("load_busy", 32'(busy), 0);
      chk("load_ferr", 32'(frame_err), 0);
      chk("done_dm_wr_low", 32'(dm_wr), 0);
      chk("done_hold_data", 32'(dm_data), 32'hFF);

      // Restart from DONE, glitch, mid-load start_load, bad stop bit
      pulse_start();
      chk("rearm_load_done", 32'(load_done), 0);
      chk("rearm_busy", 32'(busy), 1);
      base = wa.size();
      tick(3);
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(4 * CPB);
      chk("glitch_no_write", 32'(wa.size() - base), 0);
      chk("glitch_busy", 32'(busy), 1);
      send_byte(8'h55, 1'b1);
      chk("glitch_a", wr_a(base), 32'h0);
      chk("glitch_d", wr_d(base), 32'h55);
      pulse_start();
      chk("midload_busy", 32'(busy), 1);
      send_byte(8'h12, 1'b0);
      chk("bad_stop_no_write", 32'(wa.size() - base), 1);
      chk("bad_stop_ferr", 32'(frame_err), 1);
      send_byte(8'h34, 1'b1);
      chk("midload_a", wr_a(base + 1), 32'h1);
      chk("midload_d", wr_d(base + 1), 32'h34);
      send_byte(8'h77, 1'b1);
      chk("b3_a", wr_a(base + 2), 32'h2);
      chk("b3_done", 32'(load_done), 1);
      chk("ferr_sticky", 32'(frame_err), 1);

      // Fresh load: bad stop then good byte at address 0
      pulse_start();
      chk("rearm_ferr_clr", 32'(frame_err), 0);
      base = wa.size();
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b1);
      chk("fe_nwr", 32'(wa.size() - base), 1);
      chk("fe_a", wr_a(base), 32'h0);
      chk("fe_d", wr_d(base), 32'h34);
      chk("fe_flag", 32'(frame_err), 1);

      // Reset during bit 4 of the second byte
      base = wa.size();
      send_bits(8'h9A, 4);
      rx = 1'b1;
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_dm_wr", 32'(dm_wr), 0);
      chk("mid_rst_addr", 32'(dm_addr), 0);
      chk("mid_rst_data", 32'(dm_data), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(load_done), 0);
      chk("mid_rst_ferr", 32'(frame_err), 0);
      tick(3);
      rst_n = 1'b1;
      tick(4);
      bsave = busy_cnt;
      send_byte(8'hC3, 1'b1);
      chk("post_rst_no_write", 32'(wa.size() - base), 0);
      chk("post_rst_idle", 32'(busy_cnt - bsave), 0);
      pulse_start();
      send_byte(8'h01, 1'b1);
      chk("post_rst_nwr", 32'(wa.size() - base), 1);
      chk("post_rst_a", wr_a(base), 32'h0);
      chk("post_rst_d", wr_d(base), 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_loader.md
UART_RX_LOADER -- requirements
Module: uart_rx_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200); the legal minimum is 4.
REQ-002 SHALL have parameter IMG_BYTES, default 65536, giving the number of bytes loaded per frame; the legal range is 1..2^ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 20, giving the data-memory address width.
REQ-004 clock  input  1  system clock; every flop is clocked on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start_load  input  1  single-cycle request that arms a load while idle.
REQ-007 rx  input  1  asynchronous UART serial line; idle level is high.
REQ-008 dm_addr  output  ADDR_W  data-memory write address.
REQ-009 dm_data  output  8  data-memory write byte.
REQ-010 dm_wr  output  1  data-memory write strobe, one cycle per byte.
REQ-011 busy  output  1  high while a load is armed and running.
REQ-012 load_done  output  1  high once IMG_BYTES bytes have been written.
REQ-013 frame_err  output  1  sticky flag: at least one stop-bit error occurred in the current load.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1, and all sampling uses the synchronized value.
REQ-015 SHALL implement the FSM states IDLE, WAIT_START, START, DATA, STOP, WRITE and DONE.
REQ-016 IDLE: start_load=1 clears the address counter and frame_err, then moves to WAIT_START; busy=1 in every state except IDLE and DONE.
REQ-017 WAIT_START: synchronized rx=0 moves to START and clears the bit-timer.
REQ-018 START: at timer = CLKS_PER_BIT/2 - 1, re-sample rx; rx=0 moves to DATA with the timer cleared; rx=1 is a false start and returns to WAIT_START.
REQ-019 DATA: sample once every CLKS_PER_BIT cycles, LSB first, shifting into an 8-bit register; after 8 samples move to STOP.
REQ-020 STOP: sample after CLKS_PER_BIT cycles; rx=1 moves to WRITE; rx=0 sets frame_err, discards the byte, leaves the address unchanged and returns to WAIT_START.
REQ-021 WRITE: dm_wr=1 for exactly one cycle, with dm_addr = address counter and dm_data = assembled byte stable in that cycle; the counter increments on the following edge.
REQ-022 WRITE: if the counter equals IMG_BYTES-1, move to DONE; otherwise move to WAIT_START.
REQ-023 DONE: load_done=1 and busy=0; start_load=1 clears load_done and re-enters the IDLE arming path (same cycle behaviour as REQ-016).
REQ-024 SHALL ignore start_load while busy=1.
REQ-025 Total latency from the stop-bit sample to the dm_wr pulse SHALL be 1 cycle.
REQ-026 Outside WRITE, dm_wr=0; dm_addr and dm_data hold their last values.
REQ-027 The address counter SHALL be ADDR_W bits wide and SHALL NOT wrap within a load; with IMG_BYTES=2^ADDR_W, the final write is at all-ones.
REQ-028 The bit-timer SHALL be sized to clog2(CLKS_PER_BIT) bits and SHALL count 0..CLKS_PER_BIT-1.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE and all outputs to 0, with the synchronizer and rx sample at 1 and counters and shift register at 0.
REQ-030 Reset asserted mid-byte or mid-load SHALL abandon the load with no dm_wr; after release the block waits for start_load.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT and the default IMG_BYTES.
REQ-032 Bit-level reception (synchronizer, timer, START/DATA/STOP) SHALL live in sub-module uart_rx_core, which outputs byte, byte_valid and stop_err; uart_rx_loader owns the address counter and the loading FSM.

Verification (bench: CLKS_PER_BIT=4, IMG_BYTES=3)
REQ-033 Pulse start_load, then send 0xA5, 0x3C, 0xFF -> dm_wr pulses at addr 0,1,2 with data A5, 3C, FF; load_done=1, busy=0, frame_err=0.
REQ-034 Send 0x12 with stop bit=0, then 0x34 -> frame_err=1, no write for 0x12, 0x34 written at addr 0.
REQ-035 Drive a 1-cycle low glitch on rx in WAIT_START -> false start, no write, next valid byte 0x55 written at addr 0.
REQ-036 Send bytes while in IDLE without start_load -> no dm_wr; busy stays 0.
REQ-037 Assert rst_n=0 during bit 4 of the second byte, release, then start_load and send 0x01 -> written at addr 0, all outputs 0 during reset.
REQ-038 Pulse start_load mid-load and again in DONE -> ignored mid-load; in DONE, load_done clears and the address restarts at 0.
